// File: rtl/datamem_arbiter.sv
// Two-port arbiter for the single data memory port: CPU (port 0) has priority,
// a starvation counter eventually promotes the auxiliary master (port 1).
module datamem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_size,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [3:0]        aux_size,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]         starve_cnt_r;
  logic [MEM_LAT-1:0] tag_valid_r;
  logic [MEM_LAT-1:0] tag_owner_r;
  logic               aux_pri_s;
  logic               cpu_sel_s;
  logic               aux_sel_s;

  // Grant selection; grants are gated by reset so nothing issues while it is held.
  always_comb begin
    aux_pri_s = (starve_cnt_r == LIMIT);
    cpu_sel_s = 1'b0;
    aux_sel_s = 1'b0;
    if (!reset) begin
      cpu_sel_s = 1'b0;
      aux_sel_s = 1'b0;
    end else if (aux_pri_s && aux_req) begin
      aux_sel_s = 1'b1;
    end else if (cpu_req) begin
      cpu_sel_s = 1'b1;
    end else if (aux_req) begin
      aux_sel_s = 1'b1;
    end else begin
      cpu_sel_s = 1'b0;
      aux_sel_s = 1'b0;
    end
  end

  // Memory port mux driven from the granted requester, zero when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = 4'd0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case ({cpu_sel_s, aux_sel_s})
      2'b10: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_size  = cpu_size;
        mem_we    = cpu_we;
        mem_re    = ~cpu_we;
      end
      2'b01: begin
        mem_addr  = aux_addr;
        mem_wdata = aux_wdata;
        mem_size  = aux_size;
        mem_we    = aux_we;
        mem_re    = ~aux_we;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = 4'd0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
      end
    endcase
  end

  // Grant and stall outputs.
  always_comb begin
    cpu_gnt   = cpu_sel_s;
    aux_gnt   = aux_sel_s;
    cpu_stall = cpu_req & ~cpu_sel_s & reset;
  end

  // Consecutive denied aux cycles; cleared when aux is served or withdraws.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 4'd0;
    end else if (aux_sel_s) begin
      starve_cnt_r <= 4'd0;
    end else if (aux_req) begin
      if (starve_cnt_r != LIMIT) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

  // Read tag pipeline {valid, owner}; owner 1 means aux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_r <= '0;
      tag_owner_r <= '0;
    end else begin
      tag_valid_r[0] <= mem_re;
      tag_owner_r[0] <= aux_sel_s;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_owner_r[i] <= tag_owner_r[i-1];
      end
    end
  end

  assign cpu_rvalid = tag_valid_r[MEM_LAT-1] & ~tag_owner_r[MEM_LAT-1];
  assign aux_rvalid = tag_valid_r[MEM_LAT-1] &  tag_owner_r[MEM_LAT-1];
  assign cpu_rdata  = mem_rdata;
  assign aux_rdata  = mem_rdata;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed + random bench for datamem_arbiter at MEM_LAT=1 and MEM_LAT=2, checked
// against a cycle-history reference model of grants and read returns.
module tb_datamem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [63:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata, mem_rdata;
  logic [3:0]  cpu_size, aux_size;

  logic        cpu_gnt1, cpu_stall1, cpu_rvalid1, aux_gnt1, aux_rvalid1, mem_we1, mem_re1;
  logic [63:0] cpu_rdata1, aux_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_size1;
  logic        cpu_gnt2, cpu_stall2, cpu_rvalid2, aux_gnt2, aux_rvalid2, mem_we2, mem_re2;
  logic [63:0] cpu_rdata2, aux_rdata2, mem_addr2, mem_wdata2;
  logic [3:0]  mem_size2;

  datamem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_gnt(cpu_gnt1), .cpu_stall(cpu_stall1),
    .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_size(aux_size), .aux_gnt(aux_gnt1), .aux_rvalid(aux_rvalid1), .aux_rdata(aux_rdata1),
    .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_re(mem_re1), .mem_wdata(mem_wdata1),
    .mem_size(mem_size1), .mem_rdata(mem_rdata)
  );

  datamem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT), .MEM_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_gnt(cpu_gnt2), .cpu_stall(cpu_stall2),
    .cpu_rvalid(cpu_rvalid2), .cpu_rdata(cpu_rdata2),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_size(aux_size), .aux_gnt(aux_gnt2), .aux_rvalid(aux_rvalid2), .aux_rdata(aux_rdata2),
    .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_re(mem_re2), .mem_wdata(mem_wdata2),
    .mem_size(mem_size2), .mem_rdata(mem_rdata)
  );

  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   aux_wait = 0;
  int   hist [0:2047];
  logic last_aux_gnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0; cpu_size = 4'd8;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 64'd0; aux_wdata = 64'd0; aux_size = 4'd8;
  endtask

  // One clock cycle: settle, compare against model, advance model, cross the edge.
  task automatic tick();
    logic        eg_c, eg_a, e_we, e_re;
    logic [63:0] e_addr, e_wd;
    logic [3:0]  e_sz;
    int          own1, own2;
    mem_rdata = {$urandom, $urandom};
    #4;
    eg_c = 1'b0; eg_a = 1'b0;
    if (reset) begin
      if (aux_wait >= LIMIT && aux_req) eg_a = 1'b1;
      else if (cpu_req)                 eg_c = 1'b1;
      else if (aux_req)                 eg_a = 1'b1;
    end
    e_we = 1'b0; e_re = 1'b0; e_addr = 64'd0; e_wd = 64'd0; e_sz = 4'd0;
    if (eg_c) begin
      e_we = cpu_we; e_re = !cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; e_sz = cpu_size;
    end else if (eg_a) begin
      e_we = aux_we; e_re = !aux_we; e_addr = aux_addr; e_wd = aux_wdata; e_sz = aux_size;
    end
    own1 = (reset && cyc >= 1) ? hist[cyc-1] : -1;
    own2 = (reset && cyc >= 2) ? hist[cyc-2] : -1;

    check1("cpu_gnt", cpu_gnt1, eg_c);
    check1("aux_gnt", aux_gnt1, eg_a);
    check1("cpu_gnt_l2", cpu_gnt2, eg_c);
    check1("aux_gnt_l2", aux_gnt2, eg_a);
    check1("cpu_stall", cpu_stall1, reset && cpu_req && !eg_c);
    check1("mem_we", mem_we1, e_we);
    check1("mem_re", mem_re1, e_re);
    check("mem_addr", mem_addr1, e_addr);
    check("mem_wdata", mem_wdata1, e_wd);
    check("mem_size", {60'd0, mem_size1}, {60'd0, e_sz});
    check1("cpu_rvalid_l1", cpu_rvalid1, own1 == 0);
    check1("aux_rvalid_l1", aux_rvalid1, own1 == 1);
    check1("cpu_rvalid_l2", cpu_rvalid2, own2 == 0);
    check1("aux_rvalid_l2", aux_rvalid2, own2 == 1);
    if (own1 == 0) check("cpu_rdata_l1", cpu_rdata1, mem_rdata);
    if (own1 == 1) check("aux_rdata_l1", aux_rdata1, mem_rdata);
    if (own2 == 0) check("cpu_rdata_l2", cpu_rdata2, mem_rdata);
    if (own2 == 1) check("aux_rdata_l2", aux_rdata2, mem_rdata);

    hist[cyc] = ((eg_c || eg_a) && e_re) ? (eg_a ? 1 : 0) : -1;
    if (!reset) begin
      for (int k = 1; k <= 2; k++) if (cyc - k >= 0) hist[cyc-k] = -1;
    end
    if (!reset || eg_a || !aux_req) aux_wait = 0;
    else if (aux_wait < LIMIT)      aux_wait++;
    last_aux_gnt = aux_gnt1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [9:0] pattern;
    int         denials;
    bit         got;
    for (int i = 0; i < 2048; i++) hist[i] = -1;
    idle();
    mem_rdata = 64'd0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset hold with both requesting.
    cpu_req = 1'b1; aux_req = 1'b1;
    tick(); tick();
    reset = 1'b1; idle();
    tick();

    // CPU-only read at 0x40.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h40; cpu_size = 4'd8;
    tick();
    idle();
    tick(); tick();

    // Continuous contention: aux served on cycles 4 and 9.
    cpu_req = 1'b1; aux_req = 1'b1; cpu_addr = 64'h80; aux_addr = 64'h88;
    pattern = 10'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      pattern[i] = last_aux_gnt;
    end
    check("contention_pattern", {54'd0, pattern}, {54'd0, 10'b10_0001_0000});
    idle();
    tick(); tick(); tick();

    // Aux write passthrough.
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 64'h100; aux_wdata = 64'hDEADBEEF; aux_size = 4'd8;
    tick();
    idle();
    tick(); tick();

    // Interleaved reads: CPU at t, aux at t+1.
    cpu_req = 1'b1; cpu_addr = 64'h200;
    tick();
    idle(); aux_req = 1'b1; aux_addr = 64'h208;
    tick();
    idle();
    tick(); tick(); tick();

    // Same, but reset asserted at t+1 discards the outstanding read.
    cpu_req = 1'b1; cpu_addr = 64'h300;
    tick();
    idle(); aux_req = 1'b1; aux_addr = 64'h308; reset = 1'b0;
    tick();
    reset = 1'b1; idle();
    tick(); tick(); tick();

    // Counter clear: 3 denials, drop for one cycle, then aux waits 4 more.
    cpu_req = 1'b1; aux_req = 1'b1;
    tick(); tick(); tick();
    aux_req = 1'b0;
    tick();
    aux_req = 1'b1;
    denials = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (last_aux_gnt) got = 1'b1;
      else denials++;
    end
    check("counter_clear_wait", 64'(denials), 64'd4);
    idle();
    tick(); tick();

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 39) != 0);
      cpu_req   = $urandom_range(0, 2) != 0;
      cpu_we    = $urandom_range(0, 3) == 0;
      cpu_addr  = {$urandom, $urandom};
      cpu_wdata = {$urandom, $urandom};
      cpu_size  = 4'(4'd1 << $urandom_range(0, 3));
      aux_req   = $urandom_range(0, 1) != 0;
      aux_we    = $urandom_range(0, 2) == 0;
      aux_addr  = {$urandom, $urandom};
      aux_wdata = {$urandom, $urandom};
      aux_size  = 4'(4'd1 << $urandom_range(0, 3));
      tick();
    end
    reset = 1'b1; idle();
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single data memory port between two requesters: the CPU MEM stage (port 0) and an auxiliary master such as a program loader or debug/DMA engine (port 1).
- Grants at most one access per cycle. The CPU has priority, but a starvation counter guarantees the auxiliary port is eventually served.
- Tags each outstanding read and returns the read data to its owner after the memory latency.
- Produces the stall signal that freezes the CPU pipeline while the CPU is denied.

Parameters:
- ADDR_W, 64, address width of both ports and the memory.
- DATA_W, 64, data width.
- STARVE_LIMIT, 4, consecutive denied aux cycles before aux gains priority (legal range 1..15).
- MEM_LAT, 1, cycles from read grant to mem_rdata valid (legal range 1..4).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request (read or write).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_size  in  4  CPU transfer size in bytes (1/2/4/8).
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- aux_req, aux_we, aux_addr, aux_wdata, aux_size  in  1/1/ADDR_W/DATA_W/4  auxiliary port, same meaning as the CPU inputs.
- aux_gnt  out  1  aux access issued this cycle.
- aux_rvalid  out  1  aux read data valid.
- aux_rdata  out  DATA_W  aux read data.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_size  out  4  memory transfer size.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - starve_cnt=0 and all read-tag stages are invalid.
  - While reset is asserted: cpu_gnt=aux_gnt=0, mem_we=mem_re=0, cpu_rvalid=aux_rvalid=0, cpu_stall=0, mem_addr/mem_wdata/mem_size=0.
- Grant (combinational from the request inputs and registered state, issued in the same cycle as the request):
  - aux_pri = (starve_cnt == STARVE_LIMIT).
  - If aux_pri and aux_req: aux_gnt=1, cpu_gnt=0.
  - Else if cpu_req: cpu_gnt=1.
  - Else if aux_req: aux_gnt=1.
  - Never both grants in one cycle.
- Memory drive:
  - mem_addr/mem_wdata/mem_size come from the granted port; they are 0 when nothing is granted.
  - mem_we = granted port's we; mem_re = granted port's ~we.
- Starvation counter (registered):
  - aux_gnt: starve_cnt to 0.
  - else if aux_req: starve_cnt increments, saturating at STARVE_LIMIT.
  - else (aux_req=0): starve_cnt to 0.
- Read return:
  - Tag shift register of MEM_LAT stages, each holding {valid, owner}.
  - Stage 0 loads {mem_re, aux_gnt} every cycle; tags shift one stage per cycle.
  - At the last stage: cpu_rvalid = valid & ~owner, aux_rvalid = valid & owner.
  - cpu_rdata = aux_rdata = mem_rdata (unqualified; consumers use the rvalid signals).
  - Writes create no tag.
- cpu_stall = cpu_req & ~cpu_gnt, asserted in the same cycle as the denial. The pipeline holds its MEM-stage request stable until granted.
- Boundary cases:
  - Back-to-back reads from alternating owners each return in order, one per cycle.
  - Reset during an outstanding read discards the tag; no rvalid is produced after reset deasserts.
  - A requester dropping req while denied is legal; the counter clears if aux drops.
  - Requests arriving while aux_pri=1 and aux_req=0 go to the CPU normally.

Test Plan:
- Reset hold: reset=0 with cpu_req=aux_req=1 -> all grants, rvalids, mem_we, mem_re and cpu_stall are 0.
- CPU-only read, MEM_LAT=1: cpu_req=1, cpu_we=0, cpu_addr=0x40 at cycle t -> cpu_gnt=1, mem_re=1, mem_addr=0x40 at t; cpu_rvalid=1 at t+1 with cpu_rdata=mem_rdata; aux_rvalid=0.
- Contention, STARVE_LIMIT=4, both requesting continuously:
  - cycles 0-3: cpu_gnt=1.
  - cycle 4: aux_gnt=1 and cpu_stall=1.
  - cycles 5-8: cpu_gnt=1.
  - cycle 9: aux_gnt=1.
- Write passthrough: aux write addr=0x100, wdata=0xDEADBEEF, size=8, with cpu_req=0 -> aux_gnt=1, mem_we=1, mem_re=0, mem_wdata=0xDEADBEEF, mem_size=8; no rvalid afterwards.
- Interleaved reads, MEM_LAT=2:
  - CPU read at t and aux read at t+1 -> cpu_rvalid at t+2 and aux_rvalid at t+3, never both in one cycle.
  - Assert reset at t+1 -> neither rvalid ever asserts.
- Counter clear: aux_req high and denied for 3 cycles, then low for 1, then high again with cpu_req=1 -> aux waits 4 more cycles before being granted.
